// File: rtl/bram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_fifo_ctrl
// Description : First-word-fall-through FIFO controller that uses an external
//               dual-port BRAM as storage. Port 0 of the BRAM is the write
//               port and port 1 is the read port. The BRAM's 1-cycle registered
//               read latency is absorbed by a 2-entry output staging buffer.
//               The pop side therefore sees a plain valid/ready stream.
//               Total capacity is DEPTH + 2 words.
// Ports       : clk            - clock
//               rst_n          - asynchronous active-low reset
//               flush_i        - synchronous clear of all contents
//               push_valid_i   - producer has data
//               push_ready_o   - FIFO can accept
//               push_data_i    - write data
//               pop_valid_o    - head entry is available
//               pop_ready_i    - consumer accepts
//               pop_data_o     - head entry
//               count_o        - total occupancy (BRAM + in-flight + staging)
//               bram_addr_o    - [0] write pointer, [1] read pointer
//               bram_we_o      - [0] push fire, [1] tied low
//               bram_din_o     - [0] push data, [1] tied low
//               bram_dout_i    - [1] read data, valid the cycle after issue
//               err_overflow_o - (BRAM_FIFO_ERR_EN only) sticky push-while-full
//               err_underflow_o- (BRAM_FIFO_ERR_EN only) sticky pop-while-empty
// Options     : define BRAM_FIFO_ERR_EN to add the sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush_i,
  input  logic                                  push_valid_i,
  output logic                                  push_ready_o,
  input  logic [WIDTH-1:0]                      push_data_i,
  output logic                                  pop_valid_o,
  input  logic                                  pop_ready_i,
  output logic [WIDTH-1:0]                      pop_data_o,
  output logic [$clog2(DEPTH+3)-1:0]            count_o,
  output logic [1:0][$clog2(DEPTH)-1:0]         bram_addr_o,
  output logic [1:0]                            bram_we_o,
  output logic [1:0][WIDTH-1:0]                 bram_din_o,
  input  logic [1:0][WIDTH-1:0]                 bram_dout_i
`ifdef BRAM_FIFO_ERR_EN
  ,
  output logic                                  err_overflow_o,
  output logic                                  err_underflow_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DEPTH + 3);

  // State
  logic [AW-1:0]         wr_ptr_q,      wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q,      rd_ptr_d;
  logic [MW-1:0]         mem_cnt_q,     mem_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0][WIDTH-1:0] stage_q,       stage_d;
  logic [1:0]            stage_cnt_q,   stage_cnt_d;

  // Handshake and control
  logic       w_push_fire;
  logic       w_pop_fire;
  logic       w_rd_issue;
  logic [2:0] w_slots_used;
  logic [1:0] w_stage_base;
  logic       w_unused_dout;

  assign push_ready_o = (mem_cnt_q != MW'(DEPTH)) & ~flush_i;
  assign w_push_fire  = push_valid_i & push_ready_o;

  assign pop_valid_o  = (stage_cnt_q != 2'd0);
  assign pop_data_o   = stage_q[0];
  assign w_pop_fire   = pop_valid_o & pop_ready_i;

  // Staging slots that will still be claimed after this cycle's pop: held
  // entries plus the read already in flight. A new read is issued only if a
  // slot is guaranteed to be free when its data returns. pop_fire implies
  // stage_cnt >= 1, so the subtraction never wraps.
  assign w_slots_used = {1'b0, stage_cnt_q} + {2'b00, rd_inflight_q}
                      - {2'b00, w_pop_fire};
  assign w_rd_issue   = (mem_cnt_q != '0) & (w_slots_used < 3'd2) & ~flush_i;

  // First free staging slot once the pop shift has happened.
  assign w_stage_base = stage_cnt_q - {1'b0, w_pop_fire};

  // BRAM ports: port 0 write-only, port 1 read-only. A write can only hit
  // rd_ptr when the BRAM is empty, in which case no read is issued.
  assign bram_addr_o[0] = wr_ptr_q;
  assign bram_addr_o[1] = rd_ptr_q;
  assign bram_we_o[0]   = w_push_fire;
  assign bram_we_o[1]   = 1'b0;
  assign bram_din_o[0]  = push_data_i;
  assign bram_din_o[1]  = '0;

  // Read data of port 0 is never used.
  assign w_unused_dout  = ^bram_dout_i[0];

  assign count_o = CW'(mem_cnt_q) + CW'(rd_inflight_q) + CW'(stage_cnt_q);

  // Next-state logic
  always_comb begin
    wr_ptr_d      = wr_ptr_q + AW'(w_push_fire);
    rd_ptr_d      = rd_ptr_q + AW'(w_rd_issue);
    mem_cnt_d     = mem_cnt_q + MW'(w_push_fire) - MW'(w_rd_issue);
    rd_inflight_d = w_rd_issue;
    stage_d       = stage_q;
    stage_cnt_d   = w_stage_base + {1'b0, rd_inflight_q};

    if (w_pop_fire) begin
      stage_d[0] = stage_q[1];
    end

    // Returning read data lands behind whatever survives the pop.
    if (rd_inflight_q) begin
      if (w_stage_base == 2'd0) begin
        stage_d[0] = bram_dout_i[1];
      end else begin
        stage_d[1] = bram_dout_i[1];
      end
    end

    // Flush drops everything, including data returning from an in-flight read.
    if (flush_i) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      mem_cnt_d     = '0;
      rd_inflight_d = 1'b0;
      stage_cnt_d   = 2'd0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      stage_q       <= '0;
      stage_cnt_q   <= 2'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      stage_q       <= stage_d;
      stage_cnt_q   <= stage_cnt_d;
    end
  end

`ifdef BRAM_FIFO_ERR_EN
  logic err_overflow_q;
  logic err_underflow_q;

  // Sticky error flags; only reset or flush clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else if (flush_i) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      if (push_valid_i & ~push_ready_o) begin
        err_overflow_q <= 1'b1;
      end
      if (pop_ready_i & ~pop_valid_o) begin
        err_underflow_q <= 1'b1;
      end
    end
  end

  assign err_overflow_o  = err_overflow_q;
  assign err_underflow_o = err_underflow_q;
`endif

endmodule
`default_nettype wire
